id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port valid_i, input, 1: the ID-stage instruction is valid.
REQ-004 SHALL have port ctrl_i, input, 8: decoder controls, packed as {ALUOp[1:0], ALUSrc, RegWrite, MemRd, MemWr, MemToReg, immSelect} (bits 7..0).
REQ-005 SHALL have ports rs1_data_i, rs2_data_i, imm_i, input, 32 each: register-file read data and the sign-extended immediate.
REQ-006 SHALL have ports rs1_i, rs2_i, rd_i, input, 5 each: ID-stage source and destination register indices.
REQ-007 SHALL have port funct_i, input, 10: {funct7, funct3} for the ALU-control stage.
REQ-008 SHALL have port flush_i, input, 1: branch-taken kill of the ID instruction.
REQ-009 SHALL have port hold_i, input, 1: downstream (MEM) busy; freeze this stage.
REQ-010 SHALL have ports valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o, funct_o, output: registered EX-stage copies, with widths matching their inputs.
REQ-011 SHALL have port stall_o, output, 1: combinational; freezes the PC and the IF/ID register.
REQ-012 SHALL have port bubble_cnt_o, output, 8: count of inserted load-use bubbles.

Function
REQ-013 SHALL compute luh = valid_o & ctrl_o[3] (MemRd) & (rd_o != 0) & valid_i & ((rd_o == rs1_i) | ((rd_o == rs2_i) & (ctrl_i[2] | ~ctrl_i[5]))).
- The rs2 compare applies only when the ID instruction is a store (MemWr) or uses rs2 as an ALU operand (ALUSrc = 0).
REQ-014 SHALL drive stall_o = (luh | hold_i) & ~flush_i, combinationally in the same cycle.
REQ-015 SHALL apply the following priority at each rising clk_i edge: flush_i > hold_i > luh > normal load.
REQ-016 On flush_i: SHALL load valid_o = 0 and ctrl_o = 0; data, index and funct outputs keep their previous values.
REQ-017 On hold_i (flush_i = 0): SHALL keep every output register unchanged, including bubble_cnt_o.
REQ-018 On luh (no flush, no hold): SHALL insert a bubble (valid_o = 0, ctrl_o = 0) and increment bubble_cnt_o, saturating at 255.
- The ID instruction is not captured; IF/ID holds it because stall_o = 1.
REQ-019 On normal load: SHALL capture every *_i field into its *_o register and set valid_o = valid_i.
- If valid_i = 0, ctrl_o SHALL load 0 regardless of ctrl_i.
REQ-020 A bubble SHALL last exactly one cycle: luh deasserts the next cycle because valid_o = 0, and the stalled instruction then loads.
REQ-021 ctrl_o SHALL never carry RegWrite, MemRd or MemWr = 1 while valid_o = 0.
REQ-022 SHALL insert no bubble when rd_o = 0, even if rs1_i = 0 or rs2_i = 0.
REQ-023 Simultaneous flush_i and luh: SHALL perform the flush only, leave bubble_cnt_o unchanged, and hold stall_o = 0.
REQ-024 Latency SHALL be one cycle from ID inputs to EX outputs; throughput SHALL be one instruction per cycle when there is no hazard and no hold.

Reset
REQ-025 While rst_i = 0: SHALL asynchronously clear every output register to 0, including valid_o, ctrl_o, the 32-bit fields, the indices, funct_o and bubble_cnt_o.
REQ-026 In reset and the first cycle after it: stall_o SHALL be 0 unless hold_i = 1.
- A reset asserted mid-bubble or mid-hold SHALL abandon that operation; after release the stage starts empty.

Verification
REQ-027 Normal load: valid_i = 1, ctrl_i = 8'h70 (ALUOp = 01, ALUSrc, RegWrite), rs1_data_i = 32'h0000_0005, rd_i = 3 -> one edge later, valid_o = 1, ctrl_o = 8'h70, rs1_data_o = 5, rd_o = 3, stall_o = 0.
REQ-028 Load-use: EX holds lw with rd_o = 5; ID holds add with rs2_i = 5, ALUSrc = 0 -> stall_o = 1 that cycle; next edge valid_o = 0, ctrl_o = 0, bubble_cnt_o = 1; the following edge loads the add.
REQ-029 x0 destination: lw with rd_o = 0, ID rs1_i = 0 -> stall_o = 0, no bubble, bubble_cnt_o unchanged.
REQ-030 Flush priority: flush_i = 1 together with luh = 1 and hold_i = 1 -> stall_o = 0; next edge valid_o = 0, ctrl_o = 0, bubble_cnt_o unchanged.
REQ-031 Hold then saturation: hold_i = 1 for 3 cycles -> all outputs frozen; with bubble_cnt_o preloaded to 255 via 255 load-use events, one more event leaves it at 255.
REQ-032 Reset mid-operation: drop rst_i asynchronously while valid_o = 1 and bubble_cnt_o = 7 -> outputs go to 0 immediately, before any clock edge, and stay 0 until release.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID -> EX pipeline-register bus: ID-side fields in (*_i), registered EX copies
// and the hazard/stall feedback out (*_o).
interface id_ex_stage_if;
  logic        valid_i;
  logic [7:0]  ctrl_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [4:0]  rd_i;
  logic [9:0]  funct_i;
  logic        flush_i;
  logic        hold_i;

  logic        valid_o;
  logic [7:0]  ctrl_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [9:0]  funct_o;
  logic        stall_o;
  logic [7:0]  bubble_cnt_o;

  modport master (
    output valid_i, ctrl_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i,
           funct_i, flush_i, hold_i,
    input  valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
           funct_o, stall_o, bubble_cnt_o
  );

  modport slave (
    input  valid_i, ctrl_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i,
           funct_i, flush_i, hold_i,
    output valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
           funct_o, stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold control and a saturating bubble counter.
module id_ex_stage (
    input logic clk_i,
    input logic rst_i,
    id_ex_stage_if.slave bus
);

    // Handshake: valid_i qualifies every ID field in the cycle it is presented.
    // stall_o is the only back-pressure: while it is high the ID instruction is
    // not consumed and IF/ID must present it again; when low it is taken at the edge.

    logic        valid_q;
    logic [7:0]  ctrl_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [9:0]  funct_q;
    logic [7:0]  bubble_cnt_q;

    logic luh;
    logic rs1_hit;
    logic rs2_hit;
    logic rs2_used;

    always_comb begin
        rs1_hit  = (rd_q == bus.rs1_i);
        rs2_hit  = (rd_q == bus.rs2_i);
        // rs2 only matters for stores or register-register ALU ops
        rs2_used = bus.ctrl_i[2] | ~bus.ctrl_i[5];
        luh      = valid_q & ctrl_q[3] & (rd_q != 5'd0) & bus.valid_i &
                   (rs1_hit | (rs2_hit & rs2_used));
    end

    assign bus.stall_o = (luh | bus.hold_i) & ~bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            ctrl_q       <= 8'd0;
            rs1_data_q   <= 32'd0;
            rs2_data_q   <= 32'd0;
            imm_q        <= 32'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            funct_q      <= 10'd0;
            bubble_cnt_q <= 8'd0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= 8'd0;
        end else if (bus.hold_i) begin
            valid_q <= valid_q;
        end else if (luh) begin
            valid_q <= 1'b0;
            ctrl_q  <= 8'd0;
            if (bubble_cnt_q != 8'hFF) begin
                bubble_cnt_q <= bubble_cnt_q + 8'd1;
            end
        end else begin
            valid_q    <= bus.valid_i;
            // an invalid slot must never carry write/memory enables downstream
            ctrl_q     <= bus.valid_i ? bus.ctrl_i : 8'd0;
            rs1_data_q <= bus.rs1_data_i;
            rs2_data_q <= bus.rs2_data_i;
            imm_q      <= bus.imm_i;
            rs1_q      <= bus.rs1_i;
            rs2_q      <= bus.rs2_i;
            rd_q       <= bus.rd_i;
            funct_q    <= bus.funct_i;
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.ctrl_o       = ctrl_q;
    assign bus.rs1_data_o   = rs1_data_q;
    assign bus.rs2_data_o   = rs2_data_q;
    assign bus.imm_o        = imm_q;
    assign bus.rs1_o        = rs1_q;
    assign bus.rs2_o        = rs2_q;
    assign bus.rd_o         = rd_q;
    assign bus.funct_o      = funct_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour
// plus hand sequences for saturation and asynchronous reset.
module tb_id_ex_stage;
  logic clk_i;
  logic rst_i;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int n_checks;
  int n_errors;

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] rs1d;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        exp_stall;
    logic        exp_load;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_rs1d;
    logic [4:0]  exp_rd;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[22];

  logic [31:0] sh_rs2d;
  logic [31:0] sh_imm;
  logic [4:0]  sh_rs1;
  logic [4:0]  sh_rs2;
  logic [9:0]  sh_funct;
  logic [7:0]  exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: inputs change on the falling edge, settle 1 time unit
  task automatic drive(input logic f, input logic h, input logic v, input logic [7:0] c,
                       input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [9:0] fn);
    @(negedge clk_i);
    bus.flush_i    = f;
    bus.hold_i     = h;
    bus.valid_i    = v;
    bus.ctrl_i     = c;
    bus.rs1_data_i = d;
    bus.rs2_data_i = ~d;
    bus.imm_i      = d ^ 32'h0F0F_0F0F;
    bus.rs1_i      = r1;
    bus.rs2_i      = r2;
    bus.rd_i       = rd;
    bus.funct_i    = fn;
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, bus.ctrl_o}, 32'd0);
    chk({tag, "_rs1d"}, bus.rs1_data_o, 32'd0);
    chk({tag, "_rs2d"}, bus.rs2_data_o, 32'd0);
    chk({tag, "_imm"}, bus.imm_o, 32'd0);
    chk({tag, "_idx"}, {17'd0, bus.rs1_o, bus.rs2_o, bus.rd_o}, 32'd0);
    chk({tag, "_funct"}, {22'd0, bus.funct_o}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, bus.bubble_cnt_o}, 32'd0);
  endtask

  // one load-use event: lw rd=5, dependent add -> bubble, then the add loads
  task automatic luh_event;
    drive(1'b0, 1'b0, 1'b1, 8'h3A, 32'h1234, 5'd0, 5'd0, 5'd5, 10'd0);
    chk("ev_lw_stall", {31'd0, bus.stall_o}, 32'd0);
    tick;
    drive(1'b0, 1'b0, 1'b1, 8'h90, 32'h5678, 5'd5, 5'd1, 5'd6, 10'd0);
    chk("ev_luh_stall", {31'd0, bus.stall_o}, 32'd1);
    tick;
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    chk("ev_bubble_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("ev_cnt", {24'd0, bus.bubble_cnt_o}, {24'd0, exp_cnt});
    #1;
    chk("ev_after_stall", {31'd0, bus.stall_o}, 32'd0);
    tick;
    chk("ev_add_valid", {31'd0, bus.valid_o}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 8'd0;
    sh_rs2d = 32'd0; sh_imm = 32'd0; sh_rs1 = 5'd0; sh_rs2 = 5'd0; sh_funct = 10'd0;

    //            fl    ho    va    ctrl   rs1d          rs1    rs2    rd      st    ld    v     ectrl  ers1d         erd     ecnt
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h70, 32'h0000_0005, 5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b1, 8'h70, 32'h0000_0005, 5'd3,  8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0100, 5'd4,  5'd6,  5'd5,  1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0100, 5'd5,  8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h90, 32'h0000_0011, 5'd1,  5'd5,  5'd7,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0100, 5'd5,  8'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h90, 32'h0000_0011, 5'd1,  5'd5,  5'd7,  1'b0, 1'b1, 1'b1, 8'h90, 32'h0000_0011, 5'd7,  8'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0200, 5'd0,  5'd0,  5'd8,  1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0200, 5'd8,  8'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hB0, 32'h0000_0022, 5'd1,  5'd8,  5'd9,  1'b0, 1'b1, 1'b1, 8'hB0, 32'h0000_0022, 5'd9,  8'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0300, 5'd1,  5'd2,  5'd0,  1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0300, 5'd0,  8'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h90, 32'h0000_0033, 5'd0,  5'd0,  5'd4,  1'b0, 1'b1, 1'b1, 8'h90, 32'h0000_0033, 5'd4,  8'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 32'h0000_0044, 5'd0,  5'd0,  5'd2,  1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_0044, 5'd2,  8'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0500, 5'd3,  5'd0,  5'd10, 1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0500, 5'd10, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h25, 32'h0000_0066, 5'd3,  5'd10, 5'd0,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0500, 5'd10, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h25, 32'h0000_0066, 5'd3,  5'd10, 5'd0,  1'b0, 1'b1, 1'b1, 8'h25, 32'h0000_0066, 5'd0,  8'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0700, 5'd0,  5'd0,  5'd12, 1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0700, 5'd12, 8'd2};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h90, 32'h0000_0077, 5'd12, 5'd0,  5'd13, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0700, 5'd12, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h70, 32'h0000_0088, 5'd0,  5'd0,  5'd14, 1'b0, 1'b1, 1'b1, 8'h70, 32'h0000_0088, 5'd14, 8'd2};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0099, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0000_0088, 5'd14, 8'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0099, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0000_0088, 5'd14, 8'd2};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0099, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0, 1'b1, 8'h70, 32'h0000_0088, 5'd14, 8'd2};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h3A, 32'h0000_0A00, 5'd0,  5'd0,  5'd16, 1'b0, 1'b1, 1'b1, 8'h3A, 32'h0000_0A00, 5'd16, 8'd2};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h90, 32'h0000_00BB, 5'd16, 5'd0,  5'd17, 1'b1, 1'b0, 1'b1, 8'h3A, 32'h0000_0A00, 5'd16, 8'd2};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 8'h90, 32'h0000_00BB, 5'd16, 5'd0,  5'd17, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0000_0A00, 5'd16, 8'd3};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'h90, 32'h0000_00BB, 5'd16, 5'd0,  5'd17, 1'b0, 1'b1, 1'b1, 8'h90, 32'h0000_00BB, 5'd17, 8'd3};

    // reset with quiet inputs, then hold_i alone must still raise stall_o
    rst_i = 1'b0;
    bus.flush_i = 1'b0; bus.hold_i = 1'b0; bus.valid_i = 1'b0; bus.ctrl_i = 8'd0;
    bus.rs1_data_i = 32'd0; bus.rs2_data_i = 32'd0; bus.imm_i = 32'd0;
    bus.rs1_i = 5'd0; bus.rs2_i = 5'd0; bus.rd_i = 5'd0; bus.funct_i = 10'd0;
    #3;
    chk_all_zero("reset");
    chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    bus.hold_i = 1'b1;
    #1;
    chk("reset_hold_stall", {31'd0, bus.stall_o}, 32'd1);
    bus.hold_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // vector table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].flush, vecs[i].hold, vecs[i].valid, vecs[i].ctrl, vecs[i].rs1d,
            vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 10'(i * 37 + 5));
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_o}, {31'd0, vecs[i].exp_stall});
      if (vecs[i].exp_load) begin
        sh_rs2d  = ~vecs[i].rs1d;
        sh_imm   = vecs[i].rs1d ^ 32'h0F0F_0F0F;
        sh_rs1   = vecs[i].rs1;
        sh_rs2   = vecs[i].rs2;
        sh_funct = 10'(i * 37 + 5);
      end
      tick;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.valid_o}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_ctrl", i), {24'd0, bus.ctrl_o}, {24'd0, vecs[i].exp_ctrl});
      chk($sformatf("v%0d_rs1d", i), bus.rs1_data_o, vecs[i].exp_rs1d);
      chk($sformatf("v%0d_rd", i), {27'd0, bus.rd_o}, {27'd0, vecs[i].exp_rd});
      chk($sformatf("v%0d_cnt", i), {24'd0, bus.bubble_cnt_o}, {24'd0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_rs2d", i), bus.rs2_data_o, sh_rs2d);
      chk($sformatf("v%0d_imm", i), bus.imm_o, sh_imm);
      chk($sformatf("v%0d_rs", i), {22'd0, bus.rs1_o, bus.rs2_o}, {22'd0, sh_rs1, sh_rs2});
      chk($sformatf("v%0d_funct", i), {22'd0, bus.funct_o}, {22'd0, sh_funct});
    end

    // saturation: drive the counter to 255, then one more event
    exp_cnt = 8'd3;
    while (exp_cnt != 8'hFF) luh_event;
    chk("sat_at_255", {24'd0, bus.bubble_cnt_o}, 32'd255);
    luh_event;
    chk("sat_stays_255", {24'd0, bus.bubble_cnt_o}, 32'd255);

    // asynchronous reset mid-operation with valid_o = 1 and count 7
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    exp_cnt = 8'd0;
    for (int k = 0; k < 7; k++) luh_event;
    chk("pre_rst_cnt", {24'd0, bus.bubble_cnt_o}, 32'd7);
    chk("pre_rst_valid", {31'd0, bus.valid_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_stall", {31'd0, bus.stall_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 8'h70, 32'h0000_0123, 5'd1, 5'd2, 5'd3, 10'd9);
    tick;
    chk_all_zero("rst_held");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, bus.stall_o}, 32'd0);
    tick;
    chk("post_rst_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("post_rst_rs1d", bus.rs1_data_o, 32'h0000_0123);
    chk("post_rst_cnt", {24'd0, bus.bubble_cnt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
